// File: rtl/memory_request_arbiter.sv
// memory_request_arbiter
//   N-to-1 arbiter for the memory request/fulfil protocol. NUM_REQ requester
//   channels share one server channel. Round-robin (ARB_MODE=0) or fixed
//   priority with index 0 highest (ARB_MODE=1). The winning request is
//   registered toward the server and the response is routed back only to the
//   granted requester. One transaction is outstanding at a time.
//
//   Operation encoding (OP_W bits):   0 = load, 1 = store
//   Size encoding     (SIZE_W bits):  0 = byte, 1 = half, 2 = word
//   The arbiter passes both fields through unchanged.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   i_req_address[NUM_REQ]      per-requester address
//   i_req_operation[NUM_REQ]    per-requester operation
//   i_req_size[NUM_REQ]         per-requester access size
//   i_req_store_word[NUM_REQ]   per-requester store data
//   i_req_valid[NUM_REQ]        per-requester request valid
//   o_req_loaded_word[NUM_REQ]  per-requester load data (live during fulfil)
//   o_req_fulfilled[NUM_REQ]    per-requester completion pulse (same cycle as server)
//   o_srv_*                     registered request to the server
//   o_srv_valid                 request valid to the server
//   i_srv_loaded_word           server load data
//   i_srv_fulfilled             server completion pulse
//   o_grant_id                  index of current/last granted requester
//   o_busy                      transaction outstanding
module memory_request_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned OP_W     = 1,
  parameter int unsigned SIZE_W   = 2,
  localparam int unsigned GW      = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     i_req_address     [NUM_REQ],
  input  logic [OP_W-1:0]     i_req_operation   [NUM_REQ],
  input  logic [SIZE_W-1:0]   i_req_size        [NUM_REQ],
  input  logic [XLEN-1:0]     i_req_store_word  [NUM_REQ],
  input  logic [NUM_REQ-1:0]  i_req_valid,
  output logic [XLEN-1:0]     o_req_loaded_word [NUM_REQ],
  output logic [NUM_REQ-1:0]  o_req_fulfilled,
  output logic [XLEN-1:0]     o_srv_address,
  output logic [OP_W-1:0]     o_srv_operation,
  output logic [SIZE_W-1:0]   o_srv_size,
  output logic [XLEN-1:0]     o_srv_store_word,
  output logic                o_srv_valid,
  input  logic [XLEN-1:0]     i_srv_loaded_word,
  input  logic                i_srv_fulfilled,
  output logic [GW-1:0]       o_grant_id,
  output logic                o_busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  state_e          r_state;
  state_e          w_next_state;
  logic            w_capture;
  logic            w_complete;
  logic [GW-1:0]   w_win;
  logic [GW-1:0]   w_start;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_rr_ptr;
  logic [XLEN-1:0] r_srv_address;
  logic [OP_W-1:0] r_srv_operation;
  logic [SIZE_W-1:0] r_srv_size;
  logic [XLEN-1:0] r_srv_store_word;
  logic [XLEN-1:0] r_loaded [NUM_REQ];

  // First valid index found searching upward from start, wrapping at NUM_REQ-1.
  function automatic logic [GW-1:0] pick_winner(input logic [NUM_REQ-1:0] valid,
                                                input logic [GW-1:0]      start);
    logic [GW-1:0] res;
    logic [GW-1:0] cand;
    logic          found;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = GW'((32'(start) + k) % NUM_REQ);
      if (!found && valid[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Fixed priority is a round-robin search that always starts at index 0.
  assign w_start = (ARB_MODE == 1) ? '0 : r_rr_ptr;
  assign w_win   = pick_winner(i_req_valid, w_start);

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_req_valid) begin
          w_capture    = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_srv_fulfilled) begin
          w_complete   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Request capture, grant tracking and per-requester load data retention.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant          <= '0;
      r_rr_ptr         <= '0;
      r_srv_address    <= '0;
      r_srv_operation  <= '0;
      r_srv_size       <= '0;
      r_srv_store_word <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) r_loaded[i] <= '0;
    end else begin
      if (w_capture) begin
        r_grant          <= w_win;
        r_rr_ptr         <= (w_win == LAST_IDX) ? '0 : w_win + GW'(1);
        r_srv_address    <= i_req_address[w_win];
        r_srv_operation  <= i_req_operation[w_win];
        r_srv_size       <= i_req_size[w_win];
        r_srv_store_word <= i_req_store_word[w_win];
      end
      if (w_complete) r_loaded[r_grant] <= i_srv_loaded_word;
    end
  end

  // Response path: forward server data to the granted requester in the fulfil cycle.
  always_comb begin
    o_req_fulfilled = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) o_req_loaded_word[i] = r_loaded[i];
    if (w_complete) begin
      o_req_fulfilled[r_grant]   = 1'b1;
      o_req_loaded_word[r_grant] = i_srv_loaded_word;
    end
  end

  assign o_srv_valid      = (r_state == ST_BUSY);
  assign o_busy           = (r_state == ST_BUSY);
  assign o_grant_id       = r_grant;
  assign o_srv_address    = r_srv_address;
  assign o_srv_operation  = r_srv_operation;
  assign o_srv_size       = r_srv_size;
  assign o_srv_store_word = r_srv_store_word;

endmodule
